// File: rtl/mult_pkg.sv
// mult_pkg: shared payload type and sizing helpers for the stalling pipelined multiplier
package mult_pkg;

    localparam int MAX_BW    = 32;
    localparam int MAX_TAG_W = 4;

    typedef struct packed {
        logic [2*MAX_BW-1:0] acc;
        logic [MAX_BW-1:0]   a;
        logic [MAX_BW-1:0]   b;
        logic                sgn;
        logic [MAX_TAG_W-1:0] tag;
    } mult_payload_t;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/mult_pp_stage.sv
// mult_pp_stage: combinational accumulate of one multiplier slice into the running product
module mult_pp_stage
    import mult_pkg::*;
#(
    parameter int BW          = 32,
    parameter int NUM_PP      = 4,
    parameter int SHFT_OFFSET = 0
) (
    input  mult_payload_t d,
    output mult_payload_t q
);

    localparam int AW   = 2 * MAX_BW;
    localparam bit LAST = (SHFT_OFFSET + NUM_PP == BW);

    logic [AW-1:0] a_ext;
    logic [AW-1:0] pp;
    logic [AW-1:0] corr;

    // Add this slice's partial product; the slice holding the multiplier's sign bit removes twice its weight
    always_comb begin
        a_ext  = {{MAX_BW{d.sgn & d.a[MAX_BW-1]}}, d.a};
        pp     = a_ext * AW'(d.b[NUM_PP-1:0]);
        corr   = (LAST && d.sgn && d.b[NUM_PP-1]) ? a_ext << BW : '0;
        q      = d;
        q.acc  = d.acc + (pp << SHFT_OFFSET) - corr;
        q.b    = d.b >> NUM_PP;
    end

endmodule

// File: rtl/mult_pipe_stall.sv
// mult_pipe_stall: pipelined signed/unsigned multiplier with per-stage stall and bubble collapse
module mult_pipe_stall
    import mult_pkg::*;
#(
    parameter int BW     = 32,
    parameter int STAGES = 8,
    parameter int TAG_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BW-1:0]                 in_a,
    input  logic [BW-1:0]                 in_b,
    input  logic                          in_signed,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*BW-1:0]               out_prod,
    output logic [TAG_W-1:0]              out_tag,
    output logic [occ_width(STAGES)-1:0]  occupancy
);

    localparam int NUM_PP = BW / STAGES;
    localparam int OW     = occ_width(STAGES);

    if (STAGES < 1 || STAGES > BW || BW % STAGES != 0 || BW > MAX_BW || TAG_W > MAX_TAG_W) begin : g_bad_params
        $error("mult_pipe_stall: illegal BW/STAGES/TAG_W combination");
    end

    mult_payload_t     in_pl;
    mult_payload_t     src_pl  [STAGES];
    mult_payload_t     stage_d [STAGES];
    mult_payload_t     stage_q [STAGES];
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] src_vld;
    logic              in_xfer;
    logic              out_xfer;

    // Operands enter extended to payload width according to their own mode
    always_comb begin
        in_pl     = '0;
        in_pl.a   = in_signed ? MAX_BW'($signed(in_a)) : MAX_BW'(in_a);
        in_pl.b   = MAX_BW'(in_b);
        in_pl.sgn = in_signed;
        in_pl.tag = MAX_TAG_W'(in_tag);
    end

    // Each stage is fed by the input port or by the register of the stage before it
    always_comb begin
        src_pl[0]  = in_pl;
        src_vld[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_pl[k]  = stage_q[k-1];
            src_vld[k] = vld[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign adv[k] = out_ready || !(&vld[STAGES-1:k]);
        mult_pp_stage #(
            .BW          (BW),
            .NUM_PP      (NUM_PP),
            .SHFT_OFFSET (k * NUM_PP)
        ) u_pp (
            .d (src_pl[k]),
            .q (stage_d[k])
        );
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];
    assign out_prod  = stage_q[STAGES-1].acc[2*BW-1:0];
    assign out_tag   = stage_q[STAGES-1].tag[TAG_W-1:0];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Advancing stages take their source's valid bit; payload only loads when a real op moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= src_vld[k];
                    if (src_vld[k]) stage_q[k] <= stage_d[k];
                end
            end
        end
    end

    // Ops in flight: up on acceptance, down on delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occupancy <= '0;
        else        occupancy <= occupancy + OW'(in_xfer) - OW'(out_xfer);
    end

endmodule
